// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART MMIO bridge: write-FSM states, status word
// bit positions and default address-map constants.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_TX = 2'd2
  } bridge_state_e;

  // Status word layout
  localparam int RXCNT_LSB  = 0;
  localparam int RXCNT_MSB  = 2;
  localparam int OVF_BIT    = 3;
  localparam int TXBUSY_BIT = 4;
  localparam int IRQEN_BIT  = 5;

  // Default address map
  localparam logic [31:0] DEFAULT_UART_BASE   = 32'h0000_FF00;
  localparam logic [3:0]  DEFAULT_STATUS_WORD = 4'hF;
  localparam int          DEFAULT_RX_SLOTS    = 6;

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// CPU data-memory port as seen by the UART MMIO bridge.
// master = CPU side, slave = bridge side.
interface uart_mmio_bridge_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we,
    input  cpu_rdata, cpu_stall
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we,
    output cpu_rdata, cpu_stall
  );
endinterface

// File: rtl/uart_status_reg.sv
// Status/control register of the UART bridge: saturating RX byte counter,
// sticky overflow flag, IRQ enable and the registered receive interrupt.
// Optional feature macro: UART_BRIDGE_IRQ_EN (irq and irq_en implemented);
// when undefined irq is tied low and irq_en reads 0.
module uart_status_reg
  import uart_bridge_pkg::*;
#(
  parameter int RX_SLOTS = DEFAULT_RX_SLOTS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_i,
  input  logic       wr_i,
  input  logic       clr_cnt_i,
  input  logic       clr_ovf_i,
  input  logic       irq_en_i,
  output logic [2:0] rx_count_o,
  output logic       rx_ovf_o,
  output logic       irq_en_o,
  output logic       irq_o
);

  localparam logic [2:0] SLOTS = 3'(RX_SLOTS);

  logic [2:0] rx_count_q, rx_count_d;
  logic       rx_ovf_q,   rx_ovf_d;
  logic       irq_en_q,   irq_en_d;
  logic       irq_q,      irq_d;
  logic [2:0] cnt_base;

  // Next-state of counter, overflow flag, enable and interrupt
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_base   = (wr_i && clr_cnt_i) ? 3'd0 : rx_count_q;
    rx_count_d = cnt_base;
    rx_ovf_d   = (wr_i && clr_ovf_i) ? 1'b0 : rx_ovf_q;
    irq_en_d   = 1'b0;
    irq_d      = 1'b0;
    if (rx_done_i) begin
      // A clear in the same cycle counts from zero, so it yields 1, not overflow
      if (cnt_base == SLOTS) rx_ovf_d   = 1'b1;
      else                   rx_count_d = cnt_base + 3'd1;
    end
`ifdef UART_BRIDGE_IRQ_EN
    irq_en_d = wr_i ? irq_en_i : irq_en_q;
    // Built from next-state so irq drops the cycle after a clearing store
    irq_d    = irq_en_d && ((rx_count_d != 3'd0) || rx_ovf_d);
`endif
  end

`ifndef UART_BRIDGE_IRQ_EN
  logic unused_irq_en_wr;
  assign unused_irq_en_wr = irq_en_i;
`endif

  // Status state registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the same pre-edge values.
    if (reset) begin
      rx_count_q <= 3'd0;
      rx_ovf_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_count_q <= rx_count_d;
      rx_ovf_q   <= rx_ovf_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign rx_count_o = rx_count_q;
  assign rx_ovf_o   = rx_ovf_q;
  assign irq_en_o   = irq_en_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped front end for the UART: decodes the CPU data port, forwards
// stores to the UART as registered one-cycle pulses, stalls the CPU while the
// UART TX buffer is full, and exposes a status/control word.
// Optional feature macro: UART_BRIDGE_IRQ_EN (receive interrupt).
module uart_mmio_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [31:0] UART_BASE   = DEFAULT_UART_BASE,
  parameter int          RX_SLOTS    = DEFAULT_RX_SLOTS,
  parameter logic [3:0]  STATUS_WORD = DEFAULT_STATUS_WORD
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_mmio_bridge_if.slave        cpu,
  input  logic [31:0]              mem_rdata,
  output logic                     mem_we,
  output logic [15:0]              uart_address,
  output logic [31:0]              uart_wdata,
  output logic                     uart_we,
  input  logic [31:0]              uart_rdata,
  input  logic                     uart_rx_done,
  input  logic                     uart_tx_full,
  output logic                     irq
);

  logic          sel_uart, sel_stat, store_uart, store_stat;
  bridge_state_e state_q;
  logic [15:0]   addr_q;
  logic [31:0]   data_q;
  logic          uart_we_q;
  logic [2:0]    rx_count;
  logic          rx_ovf, irq_en;
  logic [31:0]   status_word;

  assign sel_uart   = (cpu.cpu_addr[31:6] == UART_BASE[31:6]);
  assign sel_stat   = sel_uart && (cpu.cpu_addr[5:2] == STATUS_WORD);
  assign store_uart = cpu.cpu_we && sel_uart && !sel_stat;
  assign store_stat = cpu.cpu_we && sel_stat;
  assign mem_we     = cpu.cpu_we && !sel_uart;

  uart_status_reg #(.RX_SLOTS(RX_SLOTS)) u_status (
    .clk        (clk),
    .reset      (reset),
    .rx_done_i  (uart_rx_done),
    .wr_i       (store_stat),
    .clr_cnt_i  (cpu.cpu_wdata[0]),
    .clr_ovf_i  (cpu.cpu_wdata[OVF_BIT]),
    .irq_en_i   (cpu.cpu_wdata[IRQEN_BIT]),
    .rx_count_o (rx_count),
    .rx_ovf_o   (rx_ovf),
    .irq_en_o   (irq_en),
    .irq_o      (irq)
  );

  // Write FSM: capture the store, wait for TX space, then issue one pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      uart_we_q <= 1'b0;
      addr_q    <= 16'h0;
      data_q    <= 32'h0;
    end else begin
      uart_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (store_uart) begin
            addr_q <= cpu.cpu_addr[15:0];
            data_q <= cpu.cpu_wdata;
            if (uart_tx_full) begin
              state_q <= WAIT_TX;
            end else begin
              state_q   <= ISSUE;
              uart_we_q <= 1'b1;
            end
          end
        end
        WAIT_TX: begin
          if (!uart_tx_full) begin
            state_q   <= ISSUE;
            uart_we_q <= 1'b1;
          end
        end
        // The CPU still holds the same store here; it is deliberately ignored
        ISSUE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_we      = uart_we_q;
  assign uart_wdata   = data_q;
  assign uart_address = (state_q == IDLE) ? cpu.cpu_addr[15:0] : addr_q;
  assign cpu.cpu_stall = !reset &&
                         (((state_q == IDLE) && store_uart) || (state_q == WAIT_TX));

  // Status word assembly and CPU load-data mux
  always_comb begin
    status_word                       = 32'h0;
    status_word[RXCNT_MSB:RXCNT_LSB]  = rx_count;
    status_word[OVF_BIT]              = rx_ovf;
    status_word[TXBUSY_BIT]           = uart_tx_full;
    status_word[IRQEN_BIT]            = irq_en;
    if (sel_stat)      cpu.cpu_rdata = status_word;
    else if (sel_uart) cpu.cpu_rdata = uart_rdata;
    else               cpu.cpu_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge with a behavioural status model
// and randomized store/load/receive traffic.
// Honours UART_BRIDGE_IRQ_EN the same way as the design.
module tb_uart_mmio_bridge;

  localparam int          RX_SLOTS  = 6;
  localparam logic [31:0] STAT_ADDR = 32'h0000_FF3C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_rdata, uart_rdata, uart_wdata;
  logic        mem_we, uart_we, uart_rx_done, uart_tx_full, irq;
  logic [15:0] uart_address;

  int errors = 0;
  int checks = 0;

  // Behavioural status model
  int m_cnt;
  bit m_ovf, m_irq_en, m_irq;

  uart_mmio_bridge_if cpu_bus ();

  uart_mmio_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cpu_bus.slave),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .uart_address (uart_address),
    .uart_wdata   (uart_wdata),
    .uart_we      (uart_we),
    .uart_rdata   (uart_rdata),
    .uart_rx_done (uart_rx_done),
    .uart_tx_full (uart_tx_full),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_irq_en = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'h0;
    s[2:0] = 3'(m_cnt);
    s[3]   = m_ovf;
    s[4]   = uart_tx_full;
    s[5]   = m_irq_en;
    return s;
  endfunction

  function automatic logic [31:0] rand_mem_addr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:6] == 26'h00003FC) a[20] = ~a[20];
    return a;
  endfunction

  function automatic logic [31:0] rand_uart_addr();
    logic [31:0] a;
    a = 32'h0000_FF00;
    a[5:2] = 4'($urandom_range(0, 14));
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // One cycle addressing the status word; checks read data and irq, then
  // advances the model by the spec rules.
  task automatic stat_cycle(input bit done, input bit wr, input logic [31:0] w);
    cpu_bus.cpu_addr = STAT_ADDR; cpu_bus.cpu_we = wr; cpu_bus.cpu_wdata = w;
    uart_rx_done = done;
    #1;
    check(cpu_bus.cpu_rdata === exp_status(),
          $sformatf("status_read: got %h expected %h", cpu_bus.cpu_rdata, exp_status()));
    check(irq === m_irq, $sformatf("irq: got %b expected %b", irq, m_irq));
    check(cpu_bus.cpu_stall === 1'b0 && mem_we === 1'b0 && uart_we === 1'b0,
          $sformatf("status_side_effects: stall=%b mem_we=%b uart_we=%b expected 0 0 0",
                    cpu_bus.cpu_stall, mem_we, uart_we));
    if (wr && w[0]) m_cnt = 0;
    if (wr && w[3]) m_ovf = 0;
    if (done) begin
      if (m_cnt == RX_SLOTS) m_ovf = 1;
      else                   m_cnt++;
    end
`ifdef UART_BRIDGE_IRQ_EN
    if (wr) m_irq_en = w[5];
    m_irq = m_irq_en && (m_cnt != 0 || m_ovf);
`endif
    tick();
    uart_rx_done = 1'b0; cpu_bus.cpu_we = 1'b0;
  endtask

  // Full UART store: holds the request while stalled, tx_full high for
  // wait_n cycles from capture.
  task automatic uart_store(input logic [31:0] a, input logic [31:0] d, input int wait_n);
    int stall_cnt = 0, pulses = 0, pulse_cyc = -1;
    bit done = 0;
    cpu_bus.cpu_addr = a; cpu_bus.cpu_wdata = d; cpu_bus.cpu_we = 1'b1;
    for (int c = 0; c < wait_n + 20 && !done; c++) begin
      uart_tx_full = (c < wait_n);
      #1;
      check(mem_we === 1'b0, $sformatf("store_mem_we: got %b expected 0", mem_we));
      if (uart_we === 1'b1) begin
        pulses++; pulse_cyc = c;
        check(uart_address === a[15:0] && uart_wdata === d,
              $sformatf("store_payload: got %h/%h expected %h/%h",
                        uart_address, uart_wdata, a[15:0], d));
      end
      if (cpu_bus.cpu_stall === 1'b1) stall_cnt++;
      else                            done = 1;
      tick();
    end
    cpu_bus.cpu_we = 1'b0; uart_tx_full = 1'b0;
    cpu_bus.cpu_addr = rand_mem_addr();
    #1;
    check(uart_we === 1'b0 && cpu_bus.cpu_stall === 1'b0,
          $sformatf("store_after: uart_we=%b stall=%b expected 0 0", uart_we, cpu_bus.cpu_stall));
    check(done, "store_timeout: stall never released, expected release");
    check(stall_cnt == wait_n + 1,
          $sformatf("store_stall_cycles: got %0d expected %0d", stall_cnt, wait_n + 1));
    check(pulses == 1 && pulse_cyc == wait_n + 1,
          $sformatf("store_pulse: got %0d pulses at cycle %0d expected 1 at %0d",
                    pulses, pulse_cyc, wait_n + 1));
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_bus.cpu_addr = 32'h0000_FF00; cpu_bus.cpu_wdata = 32'h55; cpu_bus.cpu_we = 1'b1;
    uart_rx_done = 1'b1; uart_tx_full = 1'b0;
    tick(); tick();
    #1;
    check(uart_we === 1'b0 && cpu_bus.cpu_stall === 1'b0 && irq === 1'b0,
          $sformatf("reset_outputs: uart_we=%b stall=%b irq=%b expected 0 0 0",
                    uart_we, cpu_bus.cpu_stall, irq));
    reset = 1'b0; cpu_bus.cpu_we = 1'b0; uart_rx_done = 1'b0;
    cpu_bus.cpu_addr = STAT_ADDR;
    model_reset();
    #1;
    check(cpu_bus.cpu_rdata === 32'h0,
          $sformatf("reset_status: got %h expected 0", cpu_bus.cpu_rdata));
    check(irq === 1'b0 && cpu_bus.cpu_stall === 1'b0,
          $sformatf("reset_irq_stall: irq=%b stall=%b expected 0 0", irq, cpu_bus.cpu_stall));
    tick();
  endtask

  task automatic test_reset_abort();
    cpu_bus.cpu_addr = 32'h0000_FF08; cpu_bus.cpu_wdata = 32'hDEAD_BEEF; cpu_bus.cpu_we = 1'b1;
    uart_tx_full = 1'b1;
    tick(); tick();
    reset = 1'b1; cpu_bus.cpu_we = 1'b0;
    tick();
    reset = 1'b0; uart_tx_full = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      check(uart_we === 1'b0 && cpu_bus.cpu_stall === 1'b0,
            $sformatf("reset_abort: uart_we=%b stall=%b expected 0 0", uart_we, cpu_bus.cpu_stall));
      tick();
    end
  endtask

  task automatic test_uart_store();
    uart_store(32'h0000_FF00, 32'h41, 0);
    uart_store(32'h0000_FF00, 32'h41, 5);
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 8; i++) stat_cycle(1'b1, 1'b0, 32'h0);
    #1;
    check(cpu_bus.cpu_rdata === 32'h0000_000E,
          $sformatf("rx_overflow_read: got %h expected 0000000e", cpu_bus.cpu_rdata));
    stat_cycle(1'b0, 1'b1, 32'h09);
    #1;
    check(cpu_bus.cpu_rdata === 32'h0,
          $sformatf("status_clear: got %h expected 0", cpu_bus.cpu_rdata));
    // clear and receive in the same cycle leave exactly one byte counted
    for (int i = 0; i < 3; i++) stat_cycle(1'b1, 1'b0, 32'h0);
    stat_cycle(1'b1, 1'b1, 32'h01);
    #1;
    check(cpu_bus.cpu_rdata[2:0] === 3'd1,
          $sformatf("clear_with_rx: got %0d expected 1", cpu_bus.cpu_rdata[2:0]));
    stat_cycle(1'b0, 1'b1, 32'h09);
  endtask

  task automatic test_irq();
    stat_cycle(1'b0, 1'b1, 32'h20);
    stat_cycle(1'b1, 1'b0, 32'h0);
    #1;
`ifdef UART_BRIDGE_IRQ_EN
    check(irq === 1'b1, $sformatf("irq_assert: got %b expected 1", irq));
`else
    check(irq === 1'b0 && cpu_bus.cpu_rdata === 32'h1,
          $sformatf("irq_disabled: irq=%b status=%h expected 0 00000001", irq, cpu_bus.cpu_rdata));
`endif
    stat_cycle(1'b0, 1'b1, 32'h21);
    #1;
    check(irq === 1'b0, $sformatf("irq_deassert: got %b expected 0", irq));
    stat_cycle(1'b0, 1'b1, 32'h09);
  endtask

  task automatic test_mem_path();
    for (int i = 0; i < 10; i++) begin
      cpu_bus.cpu_addr = rand_mem_addr(); cpu_bus.cpu_wdata = $urandom; cpu_bus.cpu_we = 1'b1;
      mem_rdata = $urandom;
      #1;
      check(mem_we === 1'b1 && cpu_bus.cpu_stall === 1'b0 && uart_we === 1'b0,
            $sformatf("mem_store: mem_we=%b stall=%b uart_we=%b expected 1 0 0",
                      mem_we, cpu_bus.cpu_stall, uart_we));
      tick();
      cpu_bus.cpu_we = 1'b0;
      #1;
      check(uart_we === 1'b0 && mem_we === 1'b0 && cpu_bus.cpu_rdata === mem_rdata,
            $sformatf("mem_load: uart_we=%b mem_we=%b rdata=%h expected 0 0 %h",
                      uart_we, mem_we, cpu_bus.cpu_rdata, mem_rdata));
      tick();
      cpu_bus.cpu_addr = rand_uart_addr(); uart_rdata = $urandom;
      #1;
      check(cpu_bus.cpu_rdata === uart_rdata && uart_address === cpu_bus.cpu_addr[15:0],
            $sformatf("uart_load: rdata=%h addr=%h expected %h %h",
                      cpu_bus.cpu_rdata, uart_address, uart_rdata, cpu_bus.cpu_addr[15:0]));
      tick();
    end
    cpu_bus.cpu_addr = 32'h0000_0010; cpu_bus.cpu_we = 1'b1; mem_rdata = 32'hCAFE_0010;
    #1;
    check(mem_we === 1'b1 && cpu_bus.cpu_stall === 1'b0,
          $sformatf("mem_0x10: mem_we=%b stall=%b expected 1 0", mem_we, cpu_bus.cpu_stall));
    tick();
    cpu_bus.cpu_we = 1'b0;
    #1;
    check(cpu_bus.cpu_rdata === 32'hCAFE_0010 && uart_we === 1'b0,
          $sformatf("mem_0x10_load: rdata=%h uart_we=%b expected cafe0010 0",
                    cpu_bus.cpu_rdata, uart_we));
    tick();
  endtask

  task automatic test_random_status();
    logic [31:0] w;
    for (int i = 0; i < 200; i++) begin
      uart_tx_full = ($urandom_range(0, 3) == 0);
      w = $urandom;
      stat_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0), w);
    end
    uart_tx_full = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 15; i++)
      uart_store(rand_uart_addr(), $urandom, $urandom_range(0, 4));
  endtask

  initial begin
    reset = 1'b1;
    cpu_bus.cpu_addr = 32'h0; cpu_bus.cpu_wdata = 32'h0; cpu_bus.cpu_we = 1'b0;
    mem_rdata = 32'h0; uart_rdata = 32'h0; uart_rx_done = 1'b0; uart_tx_full = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_uart_store();
    test_rx_overflow();
    test_irq();
    test_mem_path();
    test_random_status();
    test_back_to_back();
    test_reset_abort();
    test_random_status();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- Memory-mapped front end sitting directly upstream of the UART peripheral, between the CPU data-memory port and the UART/data-memory pair.
- Decodes CPU addresses and forwards stores to the UART as registered single-cycle write pulses.
- Stalls the CPU while the UART transmit buffer is flushing.
- Adds a status/control word: RX byte count, overflow flag, TX busy, IRQ enable.

Parameters:
- UART_BASE, 32'h0000_FF00, base of the 64-byte UART window; bits [5:0] ignored.
- RX_SLOTS, 6, UART receive buffer depth; saturation limit for rx_count.
- STATUS_WORD, 4'hF, word index (addr[5:2]) of the status register inside the window.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_we  in  1  CPU store strobe
- cpu_rdata  out  32  load data returned to CPU
- cpu_stall  out  1  hold the CPU PC/pipeline
- mem_rdata  in  32  data-memory read data
- mem_we  out  1  data-memory write enable
- uart_address  out  16  UART address bus
- uart_wdata  out  32  UART write data
- uart_we  out  1  UART write pulse
- uart_rdata  in  32  UART read data
- uart_rx_done  in  1  one-cycle pulse per received byte
- uart_tx_full  in  1  UART TX buffer full / transmitting
- irq  out  1  receive interrupt request

Behaviour:
- Decode: sel_uart = (cpu_addr[31:6] == UART_BASE[31:6]); sel_stat = sel_uart && cpu_addr[5:2] == STATUS_WORD.
- mem_we = cpu_we && !sel_uart. Combinational, no latency.
- cpu_rdata is combinational:
  - sel_stat: status word.
  - sel_uart otherwise: uart_rdata.
  - else: mem_rdata.
- uart_address = registered cpu_addr[15:0] when a write is captured; otherwise follows cpu_addr[15:0] combinationally so loads work.
- Status word:
  - bits [2:0] rx_count.
  - bit 3 rx_ovf, sticky.
  - bit 4 tx_busy = uart_tx_full.
  - bit 5 irq_en.
  - others 0.
- rx_count:
  - +1 on uart_rx_done, saturating at RX_SLOTS.
  - uart_rx_done while rx_count == RX_SLOTS sets rx_ovf.
- Store to status:
  - wdata bit 0 = 1 clears rx_count.
  - bit 3 = 1 clears rx_ovf (write-1-to-clear).
  - bit 5 loads irq_en.
  - A clear and a uart_rx_done in the same cycle give rx_count = 1.
- Write FSM states IDLE, ISSUE, WAIT_TX:
  - IDLE: cpu_we && sel_uart && !sel_stat captures addr/data.
    - uart_tx_full = 0: go to ISSUE; cpu_stall = 1 for this cycle.
    - uart_tx_full = 1: go to WAIT_TX; cpu_stall = 1.
  - WAIT_TX: cpu_stall = 1; go to ISSUE when uart_tx_full = 0.
  - ISSUE: uart_we = 1 for exactly one cycle with the captured address/data; cpu_stall = 0; return to IDLE.
  - A store therefore costs 2 cycles minimum.
  - A CPU store is never dropped or duplicated. The CPU holds its inputs while stalled; in ISSUE those held inputs are ignored.
- Reset values:
  - state IDLE.
  - uart_we, cpu_stall, irq = 0.
  - rx_count = 0, rx_ovf = 0, irq_en = 0.
  - captured addr/data = 0.
  - Reset during WAIT_TX or ISSUE aborts the pending write; no uart_we is issued.

Optional Feature:
- UART_BRIDGE_IRQ_EN defined:
  - irq is registered: irq = irq_en && (rx_count != 0 || rx_ovf).
  - It deasserts the cycle after the status clear.
- Undefined:
  - irq is tied 0.
  - irq_en bit reads 0 and its writes are ignored.

Decomposition:
- Package uart_bridge_pkg holds:
  - state enum (IDLE/ISSUE/WAIT_TX).
  - status bit positions (RXCNT_LSB/MSB, OVF_BIT, TXBUSY_BIT, IRQEN_BIT).
  - default UART_BASE and STATUS_WORD.
- Sub-module uart_status_reg holds rx_count, rx_ovf, irq_en and irq; the FSM and decode stay in the top.

Test Plan:
- Reset, then load 0x0000_FF3C -> cpu_rdata = 0, irq = 0, cpu_stall = 0.
- Store 0x41 to 0x0000_FF00 with uart_tx_full = 0 -> cpu_stall high 1 cycle; next cycle uart_we = 1, uart_address = 16'hFF00, uart_wdata = 0x41; mem_we never asserted.
- Same store with uart_tx_full = 1 for 5 cycles -> cpu_stall high 6 cycles; single uart_we pulse in the cycle after uart_tx_full falls.
- 8 uart_rx_done pulses -> status reads 0x0000_000E (rx_count = 6, rx_ovf = 1). Store 0x09 to status -> reads 0.
- With UART_BRIDGE_IRQ_EN: store 0x20 to status, then 1 rx_done pulse -> irq = 1 next cycle. Store 0x21 -> irq = 0 the following cycle.
- Store to 0x0000_0010 -> mem_we = 1 same cycle, no stall, no uart_we. Load from it returns mem_rdata.
